// File: rtl/bit2adder_seq.sv
// Sequential WIDTH-bit adder driving one 2-bit bit2adder slice, LS pair first.
// Optional subtract mode enabled by defining BIT2ADDER_SEQ_SUB_EN (adds the sub port).

module bit2adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] sum,
    output logic       cout,
    input  logic       cin
);

    assign {cout, sum} = a + b + {2'b00, cin};

endmodule

module bit2adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef BIT2ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [1:0]       s_sum;
    logic             s_cout;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    bit2adder u_slice (
        .a    (sh_a[1:0]),
        .b    (sh_b[1:0]),
        .sum  (s_sum),
        .cout (s_cout),
        .cin  (carry)
    );

    // Slice sums enter at the top so the first (LS) pair lands in bits [1:0] after N shifts.
    always_comb begin
        acc_next = (acc >> 2) | (WIDTH'(s_sum) << (WIDTH - 2));
    end

    always_comb begin
        b_in = op_b;
        c_in = cin;
`ifdef BIT2ADDER_SEQ_SUB_EN
        if (sub) begin
            b_in = ~op_b;
            c_in = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= op_a;
                        sh_b  <= b_in;
                        carry <= c_in;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 2;
                    sh_b  <= sh_b >> 2;
                    carry <= s_cout;
                    acc   <= acc_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        result <= acc_next;
                        cout   <= s_cout;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit2adder_seq.sv
// Self-checking bench for bit2adder_seq: WIDTH=8 vectors/random/corner cases, WIDTH=2 exhaustive.
// Subtract-mode vectors are included when BIT2ADDER_SEQ_SUB_EN is defined.

module tb_bit2adder_seq;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, res8;
`ifdef BIT2ADDER_SEQ_SUB_EN
    logic       sub8;
`endif

    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, res2;
`ifdef BIT2ADDER_SEQ_SUB_EN
    logic       sub2 = 1'b0;
`endif

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    bit2adder_seq #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .op_a   (a8),
        .op_b   (b8),
        .cin    (cin8),
`ifdef BIT2ADDER_SEQ_SUB_EN
        .sub    (sub8),
`endif
        .busy   (busy8),
        .done   (done8),
        .result (res8),
        .cout   (cout8)
    );

    bit2adder_seq #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .op_a   (a2),
        .op_b   (b2),
        .cin    (cin2),
`ifdef BIT2ADDER_SEQ_SUB_EN
        .sub    (sub2),
`endif
        .busy   (busy2),
        .done   (done2),
        .result (res2),
        .cout   (cout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] er;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 9-bit arithmetic, subtract as a + ~b + 1.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
        logic [8:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else   r = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return r;
    endfunction

    // Issue one op on the 8-bit DUT; report result, done latency (edges after accept), busy cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] r, output logic co, output int lat, output int bc,
                       output int ovl);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = -1; bc = 0; ovl = 0; r = '0; co = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy8 && done8) ovl++;
            if (done8) begin
                lat = k; r = res8; co = cout8;
                break;
            end
            if (busy8) bc++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("done8_single_pulse", int'(done8), 0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c,
                       output logic [1:0] r, output logic co, output int lat, output int bc);
        @(negedge clk);
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat = -1; bc = 0; r = '0; co = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done2) begin
                lat = k; r = res2; co = cout2;
                break;
            end
            if (busy2) bc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] r;
        logic       co;
        int         lat, bc, ovl;
`ifdef BIT2ADDER_SEQ_SUB_EN
        sub8 = v.sub;
`endif
        op8(v.a, v.b, v.cin, r, co, lat, bc, ovl);
        if (lat < 0) $display("FAIL %s_timeout: got no done expected done", tag);
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_busy_cycles"}, bc, 4);
        chk({tag, "_busy_done_overlap"}, ovl, 0);
        chk({tag, "_result"}, int'(r), int'(v.er));
        chk({tag, "_cout"}, int'(co), int'(v.ec));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] m;
        vec_t       v;
        int         dones;

        vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, er: 8'h96, ec: 1'b0});
        vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, er: 8'h00, ec: 1'b1});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, er: 8'hFF, ec: 1'b1});
        vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, er: 8'h01, ec: 1'b0});
        vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, er: 8'h00, ec: 1'b1});
`ifdef BIT2ADDER_SEQ_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b0, sub: 1'b1, er: 8'h0F, ec: 1'b1});
        vecs.push_back('{a: 8'h00, b: 8'h01, cin: 1'b1, sub: 1'b1, er: 8'hFF, ec: 1'b0});
        vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, er: 8'h96, ec: 1'b0});
        sub8 = 1'b0;
`endif

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_result8", int'(res8), 0);
        chk("rst_cout8", int'(cout8), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_result2", int'(res2), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            v.a   = 8'($urandom);
            v.b   = 8'($urandom);
            v.cin = 1'($urandom);
`ifdef BIT2ADDER_SEQ_SUB_EN
            v.sub = 1'($urandom);
`else
            v.sub = 1'b0;
`endif
            m    = model(v.a, v.b, v.cin, v.sub);
            v.er = m[7:0];
            v.ec = m[8];
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Start held high through RUN/DONE: only the second accept (at E0+6) may latch new operands.
        @(negedge clk);
`ifdef BIT2ADDER_SEQ_SUB_EN
        sub8 = 1'b0;
`endif
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'hAA;
        dones = 0;
        for (int k = 0; k <= 12; k++) begin
            if (done8) dones++;
            if (k == 4) begin
                chk("hold_done_at_4", int'(done8), 1);
                chk("hold_result1", int'(res8), 8'h46);
                chk("hold_cout1", int'(cout8), 0);
            end
            if (k == 6) start8 = 1'b0;
            if (k == 7) chk("hold_result_kept", int'(res8), 8'h46);
            if (k == 10) begin
                chk("hold_done_at_10", int'(done8), 1);
                chk("hold_result2", int'(res8), 8'h54);
                chk("hold_cout2", int'(cout8), 1);
            end
            @(negedge clk);
        end
        chk("hold_done_count", dones, 2);

        // Reset at the second RUN edge aborts the op and clears the held result.
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_result", int'(res8), 0);
        chk("abort_cout", int'(cout8), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        run_vec('{a: 8'h01, b: 8'h01, cin: 1'b0, sub: 1'b0, er: 8'h02, ec: 1'b0}, "post_abort");

        for (int i = 0; i < 32; i++) begin
            logic [4:0] sel;
            logic [1:0] r;
            logic       co;
            logic [2:0] e;
            int         lat, bc;
            sel = 5'(i);
            e   = {1'b0, sel[4:3]} + {1'b0, sel[2:1]} + {2'b00, sel[0]};
            op2(sel[4:3], sel[2:1], sel[0], r, co, lat, bc);
            chk($sformatf("w2_%0d_result", i), int'(r), int'(e[1:0]));
            chk($sformatf("w2_%0d_cout", i), int'(co), int'(e[2]));
            chk($sformatf("w2_%0d_latency", i), lat, 1);
            chk($sformatf("w2_%0d_busy", i), bc, 1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
